// File: rtl/dual_port_mem_responder.sv
// Memory-side responder for a split I/D bus: read-only port A, masked read/write port B, one shared word array.
// Each port runs its own latency FSM; resp pulses LATENCY cycles after acceptance and ports never stall each other.

module dual_port_mem_responder_fsm #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic hold_i,
  output logic accept_o,
  output logic fire_o,
  output logic resp_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  assign accept_o = (state_q == S_IDLE) && req_i;
  // fire_o marks the edge entering RESP: data capture and write commit happen there
  assign fire_o   = (accept_o && (LATENCY == 1)) ||
                    ((state_q == S_WAIT) && hold_i && (cnt_q == 4'd1));
  assign resp_o   = (state_q == S_RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!hold_i)              state_d = S_IDLE;
        else if (cnt_q == 4'd1)   state_d = S_RESP;
        else                      cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module dual_port_mem_responder #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b,
  output logic        proto_err
);
  logic [31:0] mem_q [0:(1<<ADDR_W)-1];

  logic              acc_a, fire_a, acc_b, fire_b;
  logic              req_b, hold_b;
  logic [ADDR_W-1:0] idx_a_q, idx_b_q, idx_a, idx_b;
  logic              op_wr_q, op_wr;
  logic [3:0]        wmask_q, wmask_e;
  logic [31:0]       wdata_q, wdata_e;
  logic [31:0]       rdata_a_q, rdata_b_q;
  logic              proto_err_q;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{address_a[31:ADDR_W+2], address_a[1:0],
                              address_b[31:ADDR_W+2], address_b[1:0]};

  // Read and write together is illegal, so only an exclusive request is accepted
  assign req_b  = read_b ^ write;
  assign hold_b = op_wr_q ? write : read_b;

  dual_port_mem_responder_fsm #(.LATENCY(LATENCY)) u_fsm_a (
    .clk(clk), .rst_n(rst_n), .req_i(read_a), .hold_i(read_a),
    .accept_o(acc_a), .fire_o(fire_a), .resp_o(resp_a)
  );

  dual_port_mem_responder_fsm #(.LATENCY(LATENCY)) u_fsm_b (
    .clk(clk), .rst_n(rst_n), .req_i(req_b), .hold_i(hold_b),
    .accept_o(acc_b), .fire_o(fire_b), .resp_o(resp_b)
  );

  // With LATENCY=1 the fire edge is also the accept edge, so use live inputs then
  assign idx_a   = acc_a ? address_a[ADDR_W+1:2] : idx_a_q;
  assign idx_b   = acc_b ? address_b[ADDR_W+1:2] : idx_b_q;
  assign op_wr   = acc_b ? write : op_wr_q;
  assign wmask_e = acc_b ? wmask : wmask_q;
  assign wdata_e = acc_b ? wdata : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_a_q     <= '0;
      idx_b_q     <= '0;
      op_wr_q     <= 1'b0;
      wmask_q     <= 4'd0;
      wdata_q     <= 32'd0;
      rdata_a_q   <= 32'd0;
      rdata_b_q   <= 32'd0;
      proto_err_q <= 1'b0;
    end else begin
      if (acc_a) idx_a_q <= address_a[ADDR_W+1:2];
      if (acc_b) begin
        idx_b_q <= address_b[ADDR_W+1:2];
        op_wr_q <= write;
        wmask_q <= wmask;
        wdata_q <= wdata;
      end
      if (fire_a)           rdata_a_q <= mem_q[idx_a];
      if (fire_b && !op_wr) rdata_b_q <= mem_q[idx_b];
      proto_err_q <= proto_err_q | (read_b & write);
    end
  end

  // Non-blocking update gives read-before-write against a same-edge port A capture
  always_ff @(posedge clk) begin
    if (fire_b && op_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_e[i]) mem_q[idx_b][8*i +: 8] <= wdata_e[8*i +: 8];
      end
    end
  end

  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign proto_err = proto_err_q;
endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Randomized and directed checks of dual_port_mem_responder against a word-array reference model.
module tb_dual_port_mem_responder;
  localparam int LAT  = 2;
  localparam int LAT3 = 3;
  localparam int AW   = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        read_a = 0, read_b = 0, write = 0;
  logic [31:0] address_a = 0, address_b = 0, wdata = 0;
  logic [3:0]  wmask = 0;
  logic        resp_a, resp_b, proto_err;
  logic [31:0] rdata_a, rdata_b;

  logic        read_b3 = 0, write3 = 0, read_a3 = 0;
  logic [31:0] address_b3 = 0, wdata3 = 0, address_a3 = 0;
  logic [3:0]  wmask3 = 0;
  logic        resp_b3, unused_resp_a3, unused_perr3;
  logic [31:0] rdata_b3, unused_rdata_a3;

  dual_port_mem_responder #(.LATENCY(LAT), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .read_a(read_a), .address_a(address_a),
    .resp_a(resp_a), .rdata_a(rdata_a), .read_b(read_b), .write(write),
    .wmask(wmask), .address_b(address_b), .wdata(wdata), .resp_b(resp_b),
    .rdata_b(rdata_b), .proto_err(proto_err)
  );

  dual_port_mem_responder #(.LATENCY(LAT3), .ADDR_W(AW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .read_a(read_a3), .address_a(address_a3),
    .resp_a(unused_resp_a3), .rdata_a(unused_rdata_a3), .read_b(read_b3), .write(write3),
    .wmask(wmask3), .address_b(address_b3), .wdata(wdata3), .resp_b(resp_b3),
    .rdata_b(rdata_b3), .proto_err(unused_perr3)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model [0:(1<<AW)-1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % (1 << AW));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (wm[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
  endfunction

  task automatic a_txn(input logic [31:0] addr, output logic [31:0] data, output int lat);
    read_a = 1; address_a = addr; lat = 0;
    while (!resp_a && lat < 20) begin tick(); lat++; end
    data = rdata_a; read_a = 0;
    tick();
  endtask

  task automatic b_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm, output logic [31:0] data, output int lat);
    read_b = !wr; write = wr; address_b = addr; wdata = wd; wmask = wm; lat = 0;
    while (!resp_b && lat < 20) begin tick(); lat++; end
    data = rdata_b; read_b = 0; write = 0;
    tick();
  endtask

  task automatic b3_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] data, output int lat);
    read_b3 = !wr; write3 = wr; address_b3 = addr; wdata3 = wd; wmask3 = 4'hF; lat = 0;
    while (!resp_b3 && lat < 20) begin tick(); lat++; end
    data = rdata_b3; read_b3 = 0; write3 = 0;
    tick();
  endtask

  task automatic do_wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] d; int l;
    b_txn(1'b1, addr, wd, wm, d, l);
    check_val("wr_lat", 32'(l), 32'(LAT));
    model[widx(addr)] = merge(model[widx(addr)], wd, wm);
  endtask

  task automatic do_rd_b(input string tag, input logic [31:0] addr);
    logic [31:0] d; int l;
    b_txn(1'b0, addr, 32'h0, 4'h0, d, l);
    check_val({tag, "_lat"}, 32'(l), 32'(LAT));
    check_val(tag, d, model[widx(addr)]);
  endtask

  task automatic do_rd_a(input string tag, input logic [31:0] addr);
    logic [31:0] d; int l;
    a_txn(addr, d, l);
    check_val({tag, "_lat"}, 32'(l), 32'(LAT));
    check_val(tag, d, model[widx(addr)]);
    check_val({tag, "_hold"}, rdata_a, model[widx(addr)]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, da, db, aa, ab, wd, exp_a;
    logic [3:0]  wm;
    logic [5:0]  pat, exp_pat;
    logic        seen;
    int          l, la, lb, kind;

    repeat (2) tick();
    check_val("rst_resp_a", 32'(resp_a), 32'd0);
    check_val("rst_resp_b", 32'(resp_b), 32'd0);
    check_val("rst_rdata_a", rdata_a, 32'd0);
    check_val("rst_rdata_b", rdata_b, 32'd0);
    check_val("rst_perr", 32'(proto_err), 32'd0);
    rst_n = 1;
    tick();

    do_wr(32'h40, 32'hDEADBEEF, 4'hF);
    do_rd_b("basic_rd_b", 32'h40);
    do_rd_a("basic_rd_a", 32'h40);

    do_wr(32'h80, 32'h11223344, 4'hF);
    do_wr(32'h80, 32'hAABBCCDD, 4'b0101);
    do_rd_b("mask_0101", 32'h80);
    do_wr(32'h80, 32'h55667788, 4'b0000);
    do_rd_b("mask_0000", 32'h80);

    read_a = 1; address_a = 32'h40; pat = '0; exp_pat = '0;
    for (int c = 0; c < 6; c++) begin
      pat[c] = resp_a;
      exp_pat[c] = ((c % (LAT + 1)) == LAT);
      tick();
    end
    read_a = 0;
    tick();
    check_val("b2b_pattern", 32'(pat), 32'(exp_pat));

    do_rd_a("alias_1040", 32'h1040);
    do_rd_a("alias_43", 32'h43);

    do_wr(32'h40, 32'h0, 4'hF);
    exp_a = model[widx(32'h40)];
    fork
      a_txn(32'h40, da, la);
      b_txn(1'b1, 32'h40, 32'h5, 4'hF, db, lb);
    join
    model[widx(32'h40)] = merge(model[widx(32'h40)], 32'h5, 4'hF);
    check_val("coll_rd_a", da, exp_a);
    check_val("coll_lat_a", 32'(la), 32'(LAT));
    check_val("coll_lat_b", 32'(lb), 32'(LAT));
    do_rd_a("coll_after", 32'h40);

    b3_txn(1'b1, 32'h40, 32'h12345678, d, l);
    check_val("l3_wr_lat", 32'(l), 32'(LAT3));
    write3 = 1; address_b3 = 32'h40; wdata3 = 32'hFFFFFFFF; wmask3 = 4'hF;
    tick(); tick();
    address_b3 = 32'h0;
    write3 = 0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin seen |= resp_b3; tick(); end
    check_val("abort_no_resp", 32'(seen), 32'd0);
    b3_txn(1'b0, 32'h40, 32'h0, d, l);
    check_val("abort_word", d, 32'h12345678);
    check_val("l3_rd_lat", 32'(l), 32'(LAT3));

    for (int w = 0; w < 8; w++) do_wr(32'(w) << 2, $urandom, 4'hF);
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 3);
      aa = rand_addr(); ab = rand_addr(); wd = $urandom; wm = 4'($urandom);
      case (kind)
        0: do_rd_a("rnd_rd_a", aa);
        1: do_rd_b("rnd_rd_b", ab);
        2: do_wr(ab, wd, wm);
        default: begin
          exp_a = model[widx(aa)];
          fork
            a_txn(aa, da, la);
            b_txn(1'b1, ab, wd, wm, db, lb);
          join
          model[widx(ab)] = merge(model[widx(ab)], wd, wm);
          check_val("rnd_par_a", da, exp_a);
          check_val("rnd_par_lat", 32'(la + lb), 32'(2 * LAT));
        end
      endcase
    end
    check_val("rnd_perr", 32'(proto_err), 32'd0);

    read_b = 1; write = 1; address_b = 32'h40; wdata = 32'hFFFFFFFF; wmask = 4'hF;
    seen = 0;
    tick();
    check_val("perr_set", 32'(proto_err), 32'd1);
    for (int c = 0; c < 3; c++) begin seen |= resp_b; tick(); end
    read_b = 0; write = 0;
    for (int c = 0; c < 3; c++) begin seen |= resp_b; tick(); end
    check_val("perr_no_resp", 32'(seen), 32'd0);
    check_val("perr_sticky", 32'(proto_err), 32'd1);
    do_rd_b("perr_word", 32'h40);

    do_wr(32'h84, 32'hCAFE0001, 4'hF);
    write = 1; address_b = 32'h84; wdata = 32'hFFFFFFFF; wmask = 4'hF;
    tick();
    rst_n = 0;
    #1;
    check_val("rst_mid_resp", 32'(resp_b), 32'd0);
    check_val("rst_mid_perr", 32'(proto_err), 32'd0);
    tick();
    check_val("rst_mid_resp2", 32'(resp_b), 32'd0);
    write = 0;
    rst_n = 1;
    tick();
    do_rd_b("rst_mid_word", 32'h84);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dual_port_mem_responder.md
Name: dual_port_mem_responder

Overview:
- Synthesizable responder for the CPU's split instruction/data memory interface: the memory end of the read/write/resp handshake that the core initiates.
- Port A is a read-only instruction port; port B is a read/write data port with a byte mask.
- Each port has an independent latency FSM over one shared word array, so the core can be exercised against non-zero, configurable memory latency.

Parameters:
- LATENCY, 2, cycles from request acceptance to resp; legal range 1..15.
- ADDR_W, 10, word-index width; the array holds 2**ADDR_W 32-bit words.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- read_a  in  1  port A read request, held high until resp_a.
- address_a  in  32  port A byte address.
- resp_a  out  1  port A response pulse.
- rdata_a  out  32  port A read data, valid while resp_a=1.
- read_b  in  1  port B read request.
- write  in  1  port B write request.
- wmask  in  4  port B byte enables; bit i selects wdata[8i+7:8i].
- address_b  in  32  port B byte address.
- wdata  in  32  port B write data.
- resp_b  out  1  port B response pulse.
- rdata_b  out  32  port B read data, valid while resp_b=1 for reads.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0): resp_a=0, resp_b=0, rdata_a=0, rdata_b=0, proto_err=0, both FSMs go to IDLE, counters clear. Array contents are not reset.
- Word index = address[ADDR_W+1:2]. address[1:0] and bits above ADDR_W+1 are ignored, so addresses wrap modulo array size.
- Per-port FSM states: IDLE, WAIT, RESP.
- IDLE: request high at a clock edge -> accept.
  - Latch word index, op (rd/wr), wmask and wdata.
  - Load cnt=LATENCY-1.
  - Next state is RESP if LATENCY=1, else WAIT.
- WAIT: cnt decrements each cycle; at cnt==1 the next state is RESP.
- RESP: resp=1 for exactly one cycle, then IDLE.
  - resp rises exactly LATENCY cycles after the accepting edge.
  - Request still high in the following IDLE cycle = new request. Back-to-back throughput is 1 per LATENCY+1 cycles.
- Read data: captured from the array on the edge entering RESP, and held until the next response. rdata is unchanged after resp falls.
- Write commit:
  - Occurs on the edge entering RESP. Only bytes with wmask=1 update.
  - wmask=0000 is still a valid write: resp is given, no bytes change.
  - rdata_b is not updated for writes.
- Abort: if the request drops while in WAIT, the FSM returns to IDLE next edge with no resp and no write commit. Latched values are used, so address changes mid-transaction are ignored.
- Port B read and write both high in IDLE:
  - proto_err set (sticky until reset); request not accepted; FSM stays IDLE.
  - If both are high during WAIT, proto_err is set and the transaction continues.
- Same-word collision: a port B commit and a port A capture on the same edge -> A captures the pre-write value (read-before-write). Port B reads see its own earlier completed writes.
- Ports never stall each other; A and B may respond on the same cycle.
- Reset mid-transaction: pending transaction dropped, no resp, uncommitted write discarded.

Test Plan:
- Basic write then read, LATENCY=2:
  - B write addr 0x40, wdata 0xDEADBEEF, wmask 1111 -> resp_b exactly 2 cycles after accept.
  - Then B read 0x40 -> rdata_b=0xDEADBEEF with resp_b.
  - Then A read 0x40 -> rdata_a=0xDEADBEEF.
- Byte mask:
  - Word 0x80 holds 0x11223344; write 0xAABBCCDD with wmask 0101 -> read gives 0x11BB33DD.
  - wmask 0000 -> resp_b given, word unchanged.
- Back-to-back / wrap, ADDR_W=10:
  - read_a held high 6 cycles at LATENCY=2 -> resp_a on cycles 2 and 5 only.
  - Address 0x1040 aliases 0x40; address 0x43 reads word 0x40.
- Collision and abort:
  - A read and B write of 0x40 (old 0x0, new 0x5) accepted same edge -> rdata_a=0x0; a later A read returns 0x5.
  - B write dropped in WAIT (LATENCY=3) -> no resp_b, word unchanged.
- Protocol error: read_b=write=1 in IDLE -> proto_err=1 next edge, no resp_b, stays 1 until rst_n low.
- Reset mid-op: rst_n low during port B write WAIT -> resp_b=0 immediately, proto_err=0, word unchanged after reset release.
